// File: rtl/sipo_rx_pkg.sv
// Shared types and constants for the LSB-first serial receiver.
package sipo_rx_pkg;

  localparam int WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_e;

  // Bits needed to hold a count of 0..n (i.e. clog2(n+1)).
  function automatic int cnt_w(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < (n + 1)) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/sipo_shreg.sv
// Right-shifting, MSB-in shift register with synchronous clear (clear then shift
// when both are asserted). LOOKAHEAD exposes the value after a shift on dout.
import sipo_rx_pkg::*;

module sipo_shreg #(
  parameter int WIDTH     = WIDTH_DEF,
  parameter bit LOOKAHEAD = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             sh,
  input  logic             din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (clr) sr_d = '0;
    if (sh)  sr_d = {din, sr_d[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sr_q <= '0;
    else        sr_q <= sr_d;

  assign dout = LOOKAHEAD ? {din, sr_q[WIDTH-1:1]} : sr_q;

endmodule

// File: rtl/sipo_rx.sv
// Serial-in parallel-out receiver with one-deep valid/ready output buffer.
// Optional even-parity check enabled by defining SIPO_RX_PARITY_EN.
import sipo_rx_pkg::*;

module sipo_rx #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             in_clk,
  input  logic             in_rst_n,
  input  logic             in_si,
  input  logic             in_sv,
  input  logic             in_start,
  input  logic             in_ready,
  input  logic             in_clr,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_perr,
  output logic             o_ovf
);

  localparam int CW = cnt_w(WIDTH);
`ifdef SIPO_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             sh_clr, sh_en, done;
  logic [WIDTH-1:0] word;

  // Without parity the last data bit completes the word, so the word is read
  // as the post-shift view; with parity it is already resident when PAR ends.
  sipo_shreg #(.WIDTH(WIDTH), .LOOKAHEAD(!PAR_EN)) u_shreg (
    .clk  (in_clk),
    .rst_n(in_rst_n),
    .clr  (sh_clr),
    .sh   (sh_en),
    .din  (in_si),
    .dout (word)
  );

`ifdef SIPO_RX_PARITY_EN
  logic perr_q, perr_d, word_perr;
  assign word_perr = (^word) ^ in_si;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_clr  = 1'b0;
    sh_en   = 1'b0;
    done    = 1'b0;
    if (in_sv) begin
      if (in_start) begin
        sh_clr  = 1'b1;
        sh_en   = 1'b1;
        cnt_d   = CW'(1);
        state_d = SHIFT;
      end else begin
        case (state_q)
          SHIFT: begin
            if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef SIPO_RX_PARITY_EN
              sh_en   = 1'b1;
              cnt_d   = CW'(WIDTH);
              state_d = PAR;
`else
              done    = 1'b1;
              sh_clr  = 1'b1;
              cnt_d   = '0;
              state_d = IDLE;
`endif
            end else begin
              sh_en = 1'b1;
              cnt_d = cnt_q + CW'(1);
            end
          end
`ifdef SIPO_RX_PARITY_EN
          PAR: begin
            done    = 1'b1;
            sh_clr  = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  // Output buffer: a completing word is dropped only if the held word is not
  // being accepted on the same edge; an overrun set beats a clear.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
`ifdef SIPO_RX_PARITY_EN
    perr_d  = perr_q;
`endif
    if (in_clr) ovf_d = 1'b0;
    if (done) begin
      if (valid_q && !in_ready) begin
        ovf_d = 1'b1;
      end else begin
        data_d  = word;
        valid_d = 1'b1;
`ifdef SIPO_RX_PARITY_EN
        perr_d  = word_perr;
`endif
      end
    end else if (valid_q && in_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n)
    if (!in_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end

`ifdef SIPO_RX_PARITY_EN
  always_ff @(posedge in_clk or negedge in_rst_n)
    if (!in_rst_n) perr_q <= 1'b0;
    else           perr_q <= perr_d;
  assign o_perr = perr_q;
`else
  assign o_perr = 1'b0;
`endif

  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_ovf   = ovf_q;

endmodule

// File: doc/sipo_rx.md
# sipo_rx

Serial-in, parallel-out receiver: the deserializing end of the LSB-first serial link produced by our parallel-in/serial-out shift registers. Bits arrive one per strobe on a single data line. A frame-start marker aligns the bit counter, and completed words are handed off through a one-deep output buffer with a valid/ready handshake. An optional parity check is compiled in by macro. The block sits between the serial link and any word-oriented consumer.

## Interface
- WIDTH, 4: data bits per word, ≥2.
- in_clk  input  1  rising-edge clock.
- in_rst_n  input  1  asynchronous, active-low reset.
- in_si  input  1  serial data bit.
- in_sv  input  1  serial strobe; in_si is sampled only on edges where in_sv=1.
- in_start  input  1  frame start; meaningful only with in_sv=1, marks that bit as bit 0.
- in_ready  input  1  consumer accepts o_data on an edge where o_valid=1.
- in_clr  input  1  synchronous clear of o_ovf.
- o_data  output  WIDTH  received word, bit 0 = first bit received.
- o_valid  output  1  o_data holds an unaccepted word.
- o_perr  output  1  parity error flag for the word in o_data.
- o_ovf  output  1  sticky overrun flag.

## Operation
- FSM states: IDLE, SHIFT, PAR. PAR exists only with parity enabled.
- IDLE: waits for in_sv & in_start. That bit is captured as bit 0, count=1, next state SHIFT.
- SHIFT: each in_sv edge shifts right, MSB-in: sr <= {in_si, sr[WIDTH-1:1]}, and count increments. in_sv=0 holds all state.
- When count reaches WIDTH, the word is complete. The next state is PAR with parity enabled, otherwise IDLE.
- PAR: the next in_sv bit is the parity bit. The word is complete on that edge and the next state is IDLE.
- in_start & in_sv in SHIFT or PAR restarts the frame. The partial word is discarded silently, the bit becomes bit 0, count=1, state SHIFT.
- Word completion: the assembled word loads into the output register and o_valid is set. In the same edge the shift register is cleared and count=0.
- Overrun: a word completes while o_valid=1 and in_ready=0. The new word is dropped, the old word is kept, and o_ovf is set.
- Simultaneous accept and complete: o_valid=1 and in_ready=1 on the completion edge. The new word loads and o_valid stays 1; no overrun.
- Accept without a new word: o_valid clears next cycle and o_data holds its last value.
- Simultaneous in_clr and an overrun on the same edge: set wins, so o_ovf=1.
- Reset: outputs o_data=0, o_valid=0, o_perr=0, o_ovf=0. Internally the shift register and count are 0 and the state is IDLE. Reset mid-frame discards the partial word.

## Timing
- Output latency: o_valid rises in the cycle after the edge that samples the last bit (last data bit, or the parity bit when parity is enabled). o_data and o_perr are valid in that same cycle.
- Minimum frame: WIDTH strobes, or WIDTH+1 with parity. Back-to-back frames need no idle gap.
- in_si, in_sv and in_start must meet setup/hold to in_clk. There is no internal synchronizer.
- o_valid, once high, is held with o_data stable until the accepting edge, except when an accept and a completion coincide.
- in_ready may be high while o_valid=0; it has no effect.

## Configuration
- SIPO_RX_PARITY_EN defined:
  - Each frame carries one even-parity bit after the data.
  - o_perr = XOR(data bits) ^ parity bit, registered together with o_data.
  - A word with a parity error is still delivered.
- SIPO_RX_PARITY_EN undefined:
  - PAR state and parity logic are absent.
  - o_perr is tied to 0; the port list is unchanged.

## Structure
- Package sipo_rx_pkg holds:
  - the state enum (IDLE=2'd0, SHIFT=2'd1, PAR=2'd2);
  - the default WIDTH constant;
  - the counter-width function clog2(WIDTH+1).
- Sub-module sipo_shreg holds the WIDTH-bit shift register with shift-enable and synchronous clear. FSM, counter and output buffer stay in sipo_rx.

## Test plan
- Word receipt, WIDTH=4, parity off:
  - Stimulus: in_start on the first strobe, bits 0,1,0,1 on consecutive strobes, in_ready=1.
  - Response: o_data=4'hA, o_valid high for exactly one cycle, one cycle after the 4th strobe.
- Strobe gaps:
  - Stimulus: same 0,1,0,1 frame with in_sv=0 for 3 cycles between bits.
  - Response: o_data=4'hA and no early o_valid.
- Restart mid-frame:
  - Stimulus: bits 1,1 then in_start with bits 1,0,0,0.
  - Response: o_data=4'h1; the first partial word is never output.
- Backpressure and overrun:
  - Stimulus: in_ready=0, frames 4'h3 then 4'hC.
  - Response: o_data stays 4'h3 and o_ovf=1. Then in_clr → o_ovf=0, and in_ready → o_valid drops.
- Simultaneous accept and complete:
  - Stimulus: in_ready pulsed on the completion edge of the second frame 4'h5.
  - Response: o_data=4'h5, o_valid stays 1, o_ovf=0.
- Parity and reset, SIPO_RX_PARITY_EN defined:
  - Stimulus: data 4'h7 with parity bit 1.
  - Response: o_perr=0. The same frame with parity bit 0 gives o_perr=1.
  - Reset: in_rst_n low mid-frame → all outputs 0 immediately, and the next frame decodes correctly.
